data_bus_arbiter: RTL and testbench
===================================

Name: data_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the data-memory / memory-mapped IO port of the core.
- Master 0 is the CPU load/store unit. Master 1 is a secondary requester (program loader / debug / DMA).
- Grants one transfer at a time with round-robin fairness and holds the grant until the slave acks.
- A watchdog timeout releases a hung transfer with an error flag.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 15, cycles in BUSY without s_ack before forced completion with error (range 1..255)

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- m0_req  input  1  master 0 request; held high until m0_ack
- m0_we  input  1  master 0 write enable (0 = read)
- m0_addr  input  ADDR_W  master 0 address
- m0_wdata  input  DATA_W  master 0 write data
- m0_gnt  output  1  master 0 currently owns the bus
- m0_ack  output  1  one-cycle transfer-complete pulse
- m0_err  output  1  one-cycle pulse with m0_ack on timeout
- m0_rdata  output  DATA_W  read data, valid when m0_ack
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_ack, m1_err, m1_rdata: same as master 0
- s_req  output  1  slave request
- s_we  output  1  slave write enable
- s_addr  output  ADDR_W  slave address
- s_wdata  output  DATA_W  slave write data
- s_ack  input  1  slave completion strobe
- s_rdata  input  DATA_W  slave read data, valid with s_ack

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk.
  - Registered state: state = IDLE, owner = 0, last = 1 (so master 0 wins the first tie), tcount = 0.
  - All gnt, ack, err and s_req outputs are 0.
  - s_we, s_addr, s_wdata are 0.
  - m*_rdata is 0.
- FSM has two states: IDLE and BUSY.
- IDLE:
  - Only one request → owner = that master.
  - Both requesting → owner = !last.
  - Neither → stay IDLE.
  - On a grant decision, go to BUSY at the next edge and clear tcount.
- BUSY:
  - m{owner}_gnt = 1 and s_req = 1.
  - s_we, s_addr, s_wdata mux combinationally from the owner's inputs.
  - The non-owner's gnt/ack/err are 0.
  - s_ack = 1 → m{owner}_ack = 1 the same cycle, m{owner}_rdata = s_rdata (combinational pass-through). Next edge: state = IDLE, last = owner.
  - s_ack = 0 and tcount == TIMEOUT-1 → m{owner}_ack = 1, m{owner}_err = 1, m{owner}_rdata = 0. Next edge: IDLE, last = owner.
  - Otherwise tcount increments (8-bit, saturating never reached).
  - Owner drops m{owner}_req before completion → abort: s_req = 0 that cycle (combinational gating), no ack, next edge IDLE, last = owner.
- Outputs in IDLE: s_req = 0; s_we/s_addr/s_wdata = 0; m*_rdata = 0.
- Latency and throughput:
  - Request seen in IDLE at edge N → gnt and s_req high from cycle N+1.
  - Earliest ack is in cycle N+1; bus returns to IDLE at N+2.
  - A held-high competing request is granted at N+3. Minimum 2 cycles per transfer; no back-to-back grants.
- Simultaneous events:
  - s_ack and timeout in the same cycle → normal ack, err = 0.
  - s_ack while the owner's req is low → ignored (abort wins).
- A new request arriving while BUSY waits; it is never preempted.
- s_ack in IDLE is ignored.
- Masters must hold we/addr/wdata stable while gnt = 1.
- Reset asserted mid-transfer → immediate return to reset values; the in-flight transfer is lost with no ack.

Test Plan:
- Single read: m0_req = 1, addr 0x00000100, s_ack in the 3rd BUSY cycle with s_rdata 0xDEADBEEF → m0_gnt high 3 cycles, s_addr = 0x100, s_we = 0, m0_ack for 1 cycle with m0_rdata 0xDEADBEEF, m1_* all 0.
- Tie then round-robin: m0_req and m1_req both asserted after reset, slave acks the 1st BUSY cycle each time → grant order 0,1,0,1; each gnt lasts 1 cycle separated by 1 IDLE cycle.
- Write pass-through: m1 write addr 0xFFFFFFFF, data 0x000000A5 → s_we = 1, s_addr = 0xFFFFFFFF, s_wdata = 0xA5 while m1_gnt; m1_ack on s_ack.
- Timeout: m0_req, s_ack held 0 → m0_ack = 1 and m0_err = 1 in the 15th BUSY cycle, m0_rdata = 0, IDLE next cycle; pending m1_req granted 1 cycle later.
- Abort: m1 granted, m1_req dropped in the 2nd BUSY cycle → s_req low that same cycle, no m1_ack, IDLE next edge; a late s_ack produces no response.
- Async reset mid-BUSY: assert rst between edges with m0 owning the bus → gnt, s_req, s_addr drop to 0 immediately; after release, a tie grants m0 first.

Source files
------------

// File: rtl/data_bus_arbiter.sv
// Two-master, one-slave round-robin bus arbiter for the data-memory / MMIO port.
// Grant is held until the slave acks, the owner aborts, or the watchdog expires.
module data_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_req,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic              s_ack,
    input  logic [DATA_W-1:0] s_rdata
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state_reg, state_next;
    logic       owner_reg, owner_next;
    logic       last_reg, last_next;
    logic [7:0] tcount_reg, tcount_next;

    logic [1:0]        req;
    logic [1:0]        we;
    logic [ADDR_W-1:0] addr  [2];
    logic [DATA_W-1:0] wdata [2];
    logic [1:0]        gnt_vec, ack_vec, err_vec;
    logic [DATA_W-1:0] rdata_vec [2];

    logic busy, own_req, active, done_ok, timeout_hit;

    assign req      = {m1_req, m0_req};
    assign we       = {m1_we, m0_we};
    assign addr[0]  = m0_addr;
    assign addr[1]  = m1_addr;
    assign wdata[0] = m0_wdata;
    assign wdata[1] = m1_wdata;

    assign busy        = (state_reg == BUSY);
    assign own_req     = req[owner_reg];
    // An owner that drops its request aborts: the slave sees nothing this cycle.
    assign active      = busy && own_req;
    assign done_ok     = active && s_ack;
    assign timeout_hit = active && !s_ack && (tcount_reg == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            owner_reg  <= 1'b0;
            last_reg   <= 1'b1;
            tcount_reg <= 8'd0;
        end else begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            last_reg   <= last_next;
            tcount_reg <= tcount_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        last_next   = last_reg;
        tcount_next = tcount_reg;
        case (state_reg)
            IDLE: begin
                if (req != 2'b00) begin
                    state_next  = BUSY;
                    tcount_next = 8'd0;
                    if (req == 2'b11)
                        owner_next = !last_reg;
                    else
                        owner_next = req[1];
                end
            end
            BUSY: begin
                if (!own_req || done_ok || timeout_hit) begin
                    state_next = IDLE;
                    last_next  = owner_reg;
                end else begin
                    tcount_next = tcount_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign s_req   = active;
    assign s_we    = busy ? we[owner_reg]    : 1'b0;
    assign s_addr  = busy ? addr[owner_reg]  : '0;
    assign s_wdata = busy ? wdata[owner_reg] : '0;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            logic is_owner;
            assign is_owner      = busy && (owner_reg == 1'(gi));
            assign gnt_vec[gi]   = is_owner;
            assign ack_vec[gi]   = is_owner && (done_ok || timeout_hit);
            assign err_vec[gi]   = is_owner && timeout_hit;
            assign rdata_vec[gi] = (is_owner && done_ok) ? s_rdata : '0;
        end
    endgenerate

    assign m0_gnt   = gnt_vec[0];
    assign m0_ack   = ack_vec[0];
    assign m0_err   = err_vec[0];
    assign m0_rdata = rdata_vec[0];
    assign m1_gnt   = gnt_vec[1];
    assign m1_ack   = ack_vec[1];
    assign m1_err   = err_vec[1];
    assign m1_rdata = rdata_vec[1];

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: per-cycle vector table plus hand sequences
// for timeout, abort and asynchronous reset.
module tb_data_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_ack, m0_err, m1_gnt, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_we, s_ack;
    logic [31:0] s_addr, s_wdata, s_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_rdata(s_rdata)
    );

    // flags = {m0_gnt, m0_ack, m0_err, m1_gnt, m1_ack, m1_err, s_req, s_we}
    typedef struct {
        logic        rst, r0, we0, r1, we1, sack;
        logic [31:0] a0, d0, a1, d1, srd;
        logic [7:0]  flags;
        logic [31:0] saddr, swdata, rd0, rd1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst_i, input logic r0, input logic we0,
                                input logic [31:0] a0, input logic [31:0] d0,
                                input logic r1, input logic we1,
                                input logic [31:0] a1, input logic [31:0] d1,
                                input logic sack, input logic [31:0] srd,
                                input logic [7:0] flags, input logic [31:0] saddr,
                                input logic [31:0] swdata, input logic [31:0] rd0,
                                input logic [31:0] rd1);
        vec_t v;
        v.rst = rst_i; v.r0 = r0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.we1 = we1; v.a1 = a1; v.d1 = d1; v.sack = sack; v.srd = srd;
        v.flags = flags; v.saddr = saddr; v.swdata = swdata; v.rd0 = rd0; v.rd1 = rd1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    initial begin
        logic [135:0] act_v, exp_v;

        // Single read, acked in the 3rd BUSY cycle
        vecs.push_back(mk(0,1,0,32'h100,0, 0,0,0,0, 0,0,           8'h00, 0,0,0,0));
        vecs.push_back(mk(0,1,0,32'h100,0, 0,0,0,0, 0,0,           8'h82, 32'h100,0,0,0));
        vecs.push_back(mk(0,1,0,32'h100,0, 0,0,0,0, 0,0,           8'h82, 32'h100,0,0,0));
        vecs.push_back(mk(0,1,0,32'h100,0, 0,0,0,0, 1,32'hDEADBEEF, 8'hC2, 32'h100,0,32'hDEADBEEF,0));
        vecs.push_back(mk(0,0,0,0,0,       0,0,0,0, 0,0,           8'h00, 0,0,0,0));
        // Reset, then a held tie alternates 0,1,0,1 with an IDLE cycle between grants
        vecs.push_back(mk(1,0,0,0,0,       0,0,0,0, 0,0,           8'h00, 0,0,0,0));
        vecs.push_back(mk(0,1,0,32'h10,0,  1,0,32'h20,0, 0,0,      8'h00, 0,0,0,0));
        vecs.push_back(mk(0,1,0,32'h10,0,  1,0,32'h20,0, 1,32'h11111111, 8'hC2, 32'h10,0,32'h11111111,0));
        vecs.push_back(mk(0,1,0,32'h10,0,  1,0,32'h20,0, 0,0,      8'h00, 0,0,0,0));
        vecs.push_back(mk(0,1,0,32'h10,0,  1,0,32'h20,0, 1,32'h22222222, 8'h1A, 32'h20,0,0,32'h22222222));
        vecs.push_back(mk(0,1,0,32'h10,0,  1,0,32'h20,0, 0,0,      8'h00, 0,0,0,0));
        vecs.push_back(mk(0,1,0,32'h10,0,  1,0,32'h20,0, 1,32'h33333333, 8'hC2, 32'h10,0,32'h33333333,0));
        vecs.push_back(mk(0,1,0,32'h10,0,  1,0,32'h20,0, 0,0,      8'h00, 0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,       1,0,32'h20,0, 1,32'h44444444, 8'h1A, 32'h20,0,0,32'h44444444));
        vecs.push_back(mk(0,0,0,0,0,       0,0,0,0, 0,0,           8'h00, 0,0,0,0));
        // Write from master 1 at the top address
        vecs.push_back(mk(0,0,0,0,0, 1,1,32'hFFFFFFFF,32'hA5, 0,0, 8'h00, 0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 1,1,32'hFFFFFFFF,32'hA5, 0,0, 8'h13, 32'hFFFFFFFF,32'hA5,0,0));
        vecs.push_back(mk(0,0,0,0,0, 1,1,32'hFFFFFFFF,32'hA5, 1,32'h55555555, 8'h1B, 32'hFFFFFFFF,32'hA5,0,32'h55555555));
        // s_ack while IDLE is ignored
        vecs.push_back(mk(0,0,0,0,0, 0,0,0,0, 1,32'h66666666, 8'h00, 0,0,0,0));

        rst = 1'b1; s_ack = 0; s_rdata = 0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        repeat (2) @(negedge clk);
        #3;
        chk("reset_outputs", {8'h0, m0_gnt, m0_ack, m0_err, m1_gnt, m1_ack, m1_err, s_req, s_we,
                              16'h0}, 32'h0);
        chk("reset_s_addr", s_addr, 32'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst;
            m0_req = vecs[i].r0; m0_we = vecs[i].we0; m0_addr = vecs[i].a0; m0_wdata = vecs[i].d0;
            m1_req = vecs[i].r1; m1_we = vecs[i].we1; m1_addr = vecs[i].a1; m1_wdata = vecs[i].d1;
            s_ack = vecs[i].sack; s_rdata = vecs[i].srd;
            #3;
            act_v = {m0_gnt, m0_ack, m0_err, m1_gnt, m1_ack, m1_err, s_req, s_we,
                     s_addr, s_wdata, m0_rdata, m1_rdata};
            exp_v = {vecs[i].flags, vecs[i].saddr, vecs[i].swdata, vecs[i].rd0, vecs[i].rd1};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL vec%0d actual=%h expected=%h", i, act_v, exp_v);
            end else begin
                $display("ok   vec%0d outputs=%h", i, act_v);
            end
        end

        // Timeout: m0 hangs for 15 BUSY cycles while m1 queues up
        @(negedge clk); rst = 1'b1; s_ack = 0; s_rdata = 32'h00000BAD;
        m0_req = 0; m1_req = 0; m1_we = 0; m1_addr = 32'h200; m1_wdata = 0;
        @(negedge clk); rst = 1'b0; m0_req = 1; m0_we = 0; m0_addr = 32'h40;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 5) m1_req = 1;
            #3;
            if (k < 15) begin
                chk($sformatf("to_wait%0d_gnt_ack", k), {30'h0, m0_gnt, m0_ack}, 32'h2);
            end else begin
                chk("to_ack_err", {28'h0, m0_gnt, m0_ack, m0_err, m1_gnt}, 32'hE);
                chk("to_rdata_zero", m0_rdata, 32'h0);
            end
        end
        @(negedge clk); m0_req = 0; #3;
        chk("to_idle_after", {29'h0, m0_gnt, m1_gnt, s_req}, 32'h0);
        @(negedge clk); #3;
        chk("m1_granted", {30'h0, m1_gnt, s_req}, 32'h3);
        chk("m1_addr", s_addr, 32'h200);

        // Abort: m1 drops its request in the 2nd BUSY cycle, slave acks late
        @(negedge clk); m1_req = 0; s_ack = 1; #3;
        chk("abort_sreq_ack", {29'h0, s_req, m1_ack, m1_gnt}, 32'h1);
        @(negedge clk); #3;
        chk("abort_idle_noack", {28'h0, m1_gnt, m1_ack, m0_ack, s_req}, 32'h0);

        // Asynchronous reset mid-BUSY
        @(negedge clk); s_ack = 0; m0_req = 1; m0_addr = 32'h77; #3;
        @(negedge clk); #1;
        chk("pre_rst_busy", {31'h0, m0_gnt}, 32'h1);
        chk("pre_rst_addr", s_addr, 32'h77);
        #1 rst = 1'b1; m1_req = 1;
        #1;
        chk("async_rst_drop", {29'h0, m0_gnt, s_req, m1_gnt}, 32'h0);
        chk("async_rst_addr", s_addr, 32'h0);
        @(negedge clk); rst = 1'b0; #3;
        chk("post_rst_idle", {30'h0, m0_gnt, m1_gnt}, 32'h0);
        @(negedge clk); #3;
        chk("post_rst_tie_m0", {30'h0, m0_gnt, m1_gnt}, 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
